regfile_mp: RTL and testbench

Parametrised multi-read-port register file with write-through bypass and a per-register pending-write scoreboard. It sits between decode and execute in the pipelined core. It supplies operands on up to NREAD ports and flags operands whose producing instruction has issued but not yet written back. Register 0 is hardwired to zero, and all storage clears on reset.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_if.sv | 26 ++
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 59 +++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_NREAD = 2;
  localparam int unsigned ZERO_REG  = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write, issue and read-port bundle between decode/execute and the register file.
interface regfile_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREAD = 2
);
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic                   issue;
  logic [AW-1:0]          iaddr;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [NREAD-1:0]       rbusy;
  logic [AW:0]            nbusy;

  modport master (
    output we, waddr, wdata, issue, iaddr, raddr,
    input  rdata, rbusy, nbusy
  );

  modport slave (
    input  we, waddr, wdata, issue, iaddr, raddr,
    output rdata, rbusy, nbusy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write bits per register plus a registered count of pending registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [AW-1:0]    iaddr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      nbusy
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      nbusy_q, nbusy_d;
  logic             set_hit, clr_hit, inc, dec;

  always_comb begin
    set_hit = issue && (iaddr != AW'(ZERO_REG));
    clr_hit = we && (waddr != AW'(ZERO_REG));
    busy_d  = busy_q;
    if (clr_hit) busy_d[waddr] = 1'b0;
    // Set is applied last so a new producer wins over a same-cycle writeback.
    if (set_hit) busy_d[iaddr] = 1'b1;
    inc = set_hit && !busy_q[iaddr];
    dec = clr_hit && busy_q[waddr] && !(set_hit && (iaddr == waddr));
    nbusy_d = nbusy_q;
    case ({inc, dec})
      2'b10:   nbusy_d = nbusy_q + (AW+1)'(1);
      2'b01:   nbusy_d = nbusy_q - (AW+1)'(1);
      default: nbusy_d = nbusy_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign busy  = busy_q;
  assign nbusy = nbusy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write-through bypass and pending-write tracking.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NREAD  = DEF_NREAD,
  parameter bit          BYPASS = 1'b1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [AW:0]      nbusy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.we && (bus.waddr != AW'(ZERO_REG))) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk   (clk),
    .rst   (rst),
    .issue (bus.issue),
    .iaddr (bus.iaddr),
    .we    (bus.we),
    .waddr (bus.waddr),
    .busy  (busy),
    .nbusy (nbusy)
  );

  assign bus.nbusy = nbusy;

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0] ra;
    logic          hit;
    logic          zero;

    assign ra   = bus.raddr[k*AW +: AW];
    assign hit  = BYPASS && bus.we && (bus.waddr == ra);
    // Reset also masks the bypass path so outputs drop to zero immediately.
    assign zero = rst || (ra == AW'(ZERO_REG));

    assign bus.rdata[k*WIDTH +: WIDTH] = zero ? '0 : (hit ? bus.wdata : mem_q[ra]);
    assign bus.rbusy[k]                = !zero && busy[ra] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a bypass 4-port instance and a non-bypass 2-port instance share stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          we, issue;
  logic [AW-1:0] waddr, iaddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] ra [4];

  regfile_if #(.WIDTH(W), .AW(AW), .NREAD(4)) bus4 ();
  regfile_if #(.WIDTH(W), .AW(AW), .NREAD(2)) bus2 ();

  assign bus4.we    = we;
  assign bus4.waddr = waddr;
  assign bus4.wdata = wdata;
  assign bus4.issue = issue;
  assign bus4.iaddr = iaddr;
  assign bus4.raddr = {ra[3], ra[2], ra[1], ra[0]};
  assign bus2.we    = we;
  assign bus2.waddr = waddr;
  assign bus2.wdata = wdata;
  assign bus2.issue = issue;
  assign bus2.iaddr = iaddr;
  assign bus2.raddr = {ra[1], ra[0]};

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(4), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(2), .BYPASS(1'b0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic [W-1:0] m_mem [D];
  bit           m_busy [D];
  int           m_nb;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return '0;
    if (byp && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return 0;
    if (byp && we && waddr == a) return 0;
    return {31'd0, m_busy[a]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_nb = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (we && waddr != 0) begin
        m_mem[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (issue && iaddr != 0) m_busy[iaddr] = 1'b1;
      m_nb = 0;
      for (int i = 0; i < D; i++) m_nb += int'(m_busy[i]);
    end
    #1;
  endtask

  task automatic push_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back('{$sformatf("%s/d4p%0d", tag, k), 0, k, exp_data(ra[k], 1'b1)});
      sb_q.push_back('{$sformatf("%s/b4p%0d", tag, k), 1, k, exp_busy(ra[k], 1'b1)});
    end
    sb_q.push_back('{$sformatf("%s/n4", tag), 2, 0, rst ? 32'd0 : 32'(m_nb)});
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{$sformatf("%s/d2p%0d", tag, k), 3, k, exp_data(ra[k], 1'b0)});
      sb_q.push_back('{$sformatf("%s/b2p%0d", tag, k), 4, k, exp_busy(ra[k], 1'b0)});
    end
    sb_q.push_back('{$sformatf("%s/n2", tag), 5, 0, rst ? 32'd0 : 32'(m_nb)});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       got = bus4.rdata[e.port*W +: W];
        1:       got = {31'd0, bus4.rbusy[e.port]};
        2:       got = 32'(bus4.nbusy);
        3:       got = bus2.rdata[e.port*W +: W];
        4:       got = {31'd0, bus2.rbusy[e.port]};
        default: got = 32'(bus2.nbusy);
      endcase
      check_val(e.tag, got, e.exp);
    end
  endtask

  task automatic sample(input string tag);
    push_all(tag);
    #1;
    drain();
  endtask

  task automatic idle();
    we = 1'b0; issue = 1'b0; waddr = '0; iaddr = '0; wdata = '0;
  endtask

  initial begin
    idle();
    for (int k = 0; k < 4; k++) ra[k] = '0;
    model_clear();
    repeat (2) tick();
    for (int a = 0; a < D; a++) begin
      for (int k = 0; k < 4; k++) ra[k] = AW'(a);
      sample($sformatf("rst_a%0d", a));
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) ra[k] = '0;
    we = 1'b1; waddr = 0; wdata = 32'hDEADBEEF;
    tick(); idle();
    sample("x0");

    ra[0] = 5;
    we = 1'b1; waddr = 5; wdata = 32'h12345678;
    sample("byp_same");
    tick(); idle();
    sample("byp_next");

    issue = 1'b1; iaddr = 7; ra[1] = 7;
    sample("iss_same");
    tick(); idle();
    sample("iss7");
    we = 1'b1; waddr = 7; wdata = 32'hA5;
    sample("wr7_same");
    tick(); idle();
    sample("wr7");

    issue = 1'b1; iaddr = 3;
    tick(); idle();
    ra[0] = 3;
    sample("x3busy");
    issue = 1'b1; iaddr = 3; we = 1'b1; waddr = 3; wdata = 32'd9;
    tick(); idle();
    sample("setclr_same");
    issue = 1'b1; iaddr = 4; we = 1'b1; waddr = 3; wdata = 32'd10;
    tick(); idle();
    ra[1] = 4;
    sample("setclr_diff");

    we = 1'b1; waddr = 1; wdata = 32'h11;
    tick();
    waddr = 2; wdata = 32'h22;
    tick(); idle();
    issue = 1'b1; iaddr = 31;
    tick(); idle();
    ra[0] = 1; ra[1] = 2; ra[2] = 1; ra[3] = 31;
    sample("four_port");
    check_val("rbusy_vec", 32'(bus4.rbusy), 32'h8);

    // Narrow address range forces frequent write/issue/read collisions.
    repeat (300) begin
      we    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, 7));
      wdata = $urandom;
      issue = 1'($urandom_range(0, 1));
      iaddr = AW'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) ra[k] = AW'($urandom_range(0, 8));
      sample("rnd");
      tick();
    end
    idle();

    for (int r = 10; r < 15; r++) begin
      issue = 1'b1; iaddr = AW'(r);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) ra[k] = AW'(10 + k);
    sample("pre_rst");

    #2;
    we = 1'b1; waddr = 10; wdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    model_clear();
    sample("async_rst");
    tick();
    sample("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    idle();

    we = 1'b1; waddr = 6; wdata = 32'h77;
    ra[0] = 6; ra[1] = 6;
    tick(); idle();
    sample("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
